float_decode_seq: RTL and testbench
===================================

Name: float_decode_seq

Overview:
- Sequential decoder from the team's 8-bit compact float format {sign, exp[2:0], sig[3:0]} back to a 12-bit two's-complement linear sample.
- The inverse of the linear-to-float compressor. Sits on the playback side of the sample path.
- Reconstructs magnitude = sig × 2^exp using an iterative one-bit-per-cycle shifter, then applies the sign.
- Valid/ready handshakes on both sides.

Parameters:
- EXP_W, 3, exponent field width.
- SIG_W, 4, significand field width.
- OUT_W, 12, output width. Must satisfy OUT_W >= SIG_W + 2^EXP_W. With the defaults the largest magnitude is 1920, which fits in 11 bits plus sign.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word is valid.
- in_ready  out  1  block can accept an input word.
- in_sign  in  1  sign bit (1 = negative).
- in_exp  in  EXP_W  exponent.
- in_sig  in  SIG_W  significand.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  OUT_W  two's-complement linear result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, internal mag = 0, cnt = 0, sign_q = 0.
- States: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE), decoded combinationally from state. out_valid = (state == DONE).
- IDLE:
  - On an edge with in_valid = 1, the input is accepted.
  - On acceptance: mag <= zero-extended in_sig, cnt <= in_exp, sign_q <= in_sign, state <= SHIFT.
  - Inputs are sampled only at the accept edge; later changes to the inputs are ignored.
- SHIFT, when cnt != 0: mag <= mag << 1; cnt <= cnt - 1.
- SHIFT, when cnt == 0:
  - out_data <= sign_q ? (~mag + 1) : mag, computed at OUT_W width.
  - state <= DONE.
- Latency: out_valid rises exp+1 cycles after the accept edge. exp = 0 gives 1 cycle; exp = 7 gives 8 cycles.
- DONE:
  - out_data is held stable while out_ready = 0 (backpressure, unlimited duration).
  - On an edge with out_ready = 1: state <= IDLE. out_data keeps its last value; only out_valid drops.
  - No new input is accepted in the same cycle as the output handshake. Throughput is one word per (exp+3) cycles minimum.
- Negative zero: sign = 1 with sig = 0 yields out_data = 0.
- Saturation: none is needed, because the format cannot exceed the range. Saturated encoder codes (exp 7, sig 15) decode to ±1920.
- Reset mid-operation: returns to IDLE on assertion. Any in-flight word is discarded and no out_valid is produced for it.
- in_valid asserted while not in IDLE has no effect. The producer must hold the word until in_ready = 1.

Decomposition:
- Shared package (float_fmt_pkg): EXP_W, SIG_W, OUT_W constants; the state encoding (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2); a packed float-word layout {sign, exp, sig}. The encoder also uses this package.
- No sub-module is required. The negation may be a local function shared via the package.

Test Plan:
- Zero: sign = 0, exp = 0, sig = 0 -> out_data = 12'h000, out_valid 1 cycle after accept.
- Maximum positive: sign = 0, exp = 7, sig = 15 -> 12'h780 (1920), out_valid 8 cycles after accept; in_ready = 0 throughout.
- Negative: sign = 1, exp = 3, sig = 9 -> 12'hFB8 (-72), 4-cycle latency. Also sign = 1, exp = 7, sig = 15 -> 12'h880 (-1920).
- Backpressure: out_ready held 0 for 5 cycles in DONE -> out_data and out_valid stable, in_ready = 0, in_valid pulses ignored. The word is released on the first out_ready = 1 edge.
- Reset mid-shift: assert rst_n = 0 during SHIFT of exp = 6 -> out_valid = 0, out_data = 0, in_ready = 1 immediately (asynchronous). The next word, sign = 0, exp = 1, sig = 5, decodes to 12'h00A.
- Round-trip: drive all 256 codes back-to-back with randomized out_ready -> each result equals ±sig<<exp, and outputs arrive in order with no drops or duplicates.

Source files
------------

// File: rtl/float_fmt_pkg.sv
// Shared definitions for the compact 8-bit float sample format {sign, exp, sig}.
// Used by both the linear-to-float encoder and the float-to-linear decoder.
package float_fmt_pkg;

  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;
  localparam int unsigned OUT_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } float_word_t;

endpackage

// File: rtl/float_decode_seq.sv
// Sequential compact-float to linear decoder: magnitude = sig << exp,
// built one shift per cycle, then sign-applied as two's complement.
module float_decode_seq
  import float_fmt_pkg::*;
#(
  parameter int unsigned EXP_W = float_fmt_pkg::EXP_W,
  parameter int unsigned SIG_W = float_fmt_pkg::SIG_W,
  parameter int unsigned OUT_W = float_fmt_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SIG_W-1:0] in_sig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  state_t           state, state_nxt;
  logic [OUT_W-1:0] mag;
  logic [EXP_W-1:0] cnt;
  logic             sign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // out_data is only written on the final shift step, so it holds through
  // DONE and keeps its last value after the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      out_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mag    <= OUT_W'(in_sig);
            cnt    <= in_exp;
            sign_q <= in_sign;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            mag <= mag << 1;
            cnt <= cnt - EXP_W'(1);
          end else begin
            out_data <= sign_q ? (~mag + OUT_W'(1)) : mag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_decode_seq.sv
// Scoreboard bench for float_decode_seq: driver pushes expected words,
// a negedge monitor pops and checks data, latency, handshakes and holding.
module tb_float_decode_seq;
  import float_fmt_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sign = 1'b0;
  logic [EXP_W-1:0] in_exp = '0;
  logic [SIG_W-1:0] in_sig = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;

  float_decode_seq #(.EXP_W(EXP_W), .SIG_W(SIG_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    int               lat;
    int               acc;
  } exp_t;

  exp_t             q[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  bit               seen = 0;
  bit               released = 0;
  bit               rand_ready = 1;
  int               stall_req = 0;
  int               stall_cnt = 0;
  logic [OUT_W-1:0] held = '0;

  always @(posedge clk) cyc++;

  function automatic logic [OUT_W-1:0] model(input bit s, input int e, input int g);
    int v;
    v = g * (2 ** e);
    if (s) v = -v;
    return OUT_W'(v);
  endfunction

  // Monitor / consumer
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (released) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL valid_drop got out_valid=%b want 0", out_valid);
        end
        checks++;
        if (out_data !== held) begin
          errors++; $display("FAIL data_kept got %h want %h", out_data, held);
        end
      end
      if (out_valid && !seen) begin
        seen = 1;
        held = out_data;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output got %h want none", out_data);
        end else begin
          e = q.pop_front();
          checks++;
          if (out_data !== e.data) begin
            errors++; $display("FAIL data got %h want %h", out_data, e.data);
          end
          checks++;
          if (cyc - e.acc != e.lat) begin
            errors++; $display("FAIL latency got %0d want %0d", cyc - e.acc, e.lat);
          end
        end
        if (stall_req > 0) begin
          stall_cnt = stall_req;
          stall_req = 0;
        end
      end else if (out_valid && seen) begin
        checks++;
        if (out_data !== held) begin
          errors++; $display("FAIL hold_data got %h want %h", out_data, held);
        end
      end
      checks++;
      if (in_ready !== (q.size() == 0 && !seen)) begin
        errors++;
        $display("FAIL in_ready got %b want %b", in_ready, (q.size() == 0 && !seen));
      end
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      released = out_valid && out_ready;
      if (released) seen = 0;
    end else begin
      seen = 0;
      released = 0;
    end
  end

  task automatic send(input bit s, input int e, input int g);
    int w;
    int acc;
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = EXP_W'(e);
    in_sig   = SIG_W'(g);
    w = 0;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got in_ready=0 want 1");
      in_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x.data = model(s, e, g);
    x.lat  = e + 1;
    x.acc  = acc;
    q.push_back(x);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q.size() != 0 || seen) && w < 500) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (q.size() != 0 || seen) begin
      checks++; errors++;
      $display("FAIL drain_timeout got pending=%0d want 0", q.size());
    end
  endtask

  initial begin
    int w;
    float_word_t fw;
    logic [7:0] code;

    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b data=%h want 1 0 000",
               in_ready, out_valid, out_data);
    end
    #6 rst_n = 1'b1;

    // Directed corner words
    rand_ready = 0;
    send(0, 0, 0);   drain();
    send(0, 7, 15);  drain();
    send(1, 3, 9);   drain();
    send(1, 7, 15);  drain();
    send(1, 2, 0);   drain();

    // Backpressure with ignored input pulses
    stall_req = 5;
    send(0, 2, 3);
    w = 0;
    while (!seen && w < 50) begin
      @(negedge clk); #1; w++;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL bp_timeout got out_valid=0 want 1");
    end
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 3'd5; in_sig = 4'd7;
    repeat (3) begin @(negedge clk); #1; end
    in_valid = 1'b0;
    drain();

    // Asynchronous reset in the middle of a shift
    send(1, 6, 11);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got vld=%b data=%h rdy=%b want 0 000 1",
               out_valid, out_data, in_ready);
    end
    q.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    send(0, 1, 5);
    drain();

    // All 256 codes back-to-back with random consumer stalls
    rand_ready = 1;
    for (int i = 0; i < 256; i++) begin
      code = 8'(i);
      fw = float_word_t'(code);
      send(fw.sign, int'(fw.exp), int'(fw.sig));
    end
    drain();

    // A few random words with random gaps
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15));
    end
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
